// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO for the MIPS execute stage.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise DIV/DIVU retire at once with HI/LO untouched.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_SIGN = 2'b10;

    localparam int            PW   = 2 * WIDTH;
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic             r_sa;
    logic             r_sb;
    logic [WIDTH-1:0] r_ma;
    logic [WIDTH-1:0] r_mb;
    logic [PW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;

    logic             w_sgn;
    logic [WIDTH:0]   w_madd;
    logic [PW-1:0]    w_prod;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] x);
        return (~x) + WIDTH'(1);
    endfunction

    function automatic logic [PW-1:0] f_neg2(input logic [PW-1:0] x);
        return (~x) + PW'(1);
    endfunction

    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? f_neg(x) : x;
    endfunction

    // MULT and DIV (op[0] == 0) are the signed flavours
    assign w_sgn = ~op[0];

    // Shift-add step: r_mb rotates right so the current multiplier bit is always bit 0
    assign w_madd = {1'b0, r_acc[PW-1:WIDTH]} + (r_mb[0] ? {1'b0, r_ma} : '0);

`ifdef MULDIV_DIV_EN
    logic             r_isdiv;
    logic [WIDTH:0]   w_dshift;
    logic             w_qbit;
    logic [WIDTH-1:0] w_ddiff;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_a_raw;

    // Restoring step: r_ma rotates left feeding dividend bits MSB first and is whole again after WIDTH steps
    assign w_dshift = {r_acc[PW-1:WIDTH], r_ma[WIDTH-1]};
    assign w_qbit   = (w_dshift >= {1'b0, r_mb});
    assign w_ddiff  = w_dshift[WIDTH-1:0] - r_mb;
    assign w_rem_nx = w_qbit ? w_ddiff : w_dshift[WIDTH-1:0];
    assign w_a_raw  = r_sa ? f_neg(r_ma) : r_ma;
`endif

    always_comb begin
        w_prod   = (r_sa ^ r_sb) ? f_neg2(r_acc) : r_acc;
        w_res_hi = w_prod[PW-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        if (r_isdiv) begin
            if (r_mb == '0) begin
                w_res_lo = '1;
                w_res_hi = w_a_raw;
            end else begin
                w_res_lo = (r_sa ^ r_sb) ? f_neg(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
                w_res_hi = r_sa ? f_neg(r_acc[PW-1:WIDTH]) : r_acc[PW-1:WIDTH];
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_ma    <= '0;
            r_mb    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_isdiv <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_sa  <= w_sgn & a[WIDTH-1];
                        r_sb  <= w_sgn & b[WIDTH-1];
                        r_ma  <= f_abs(a, w_sgn);
                        r_mb  <= f_abs(b, w_sgn);
                        r_acc <= '0;
                        r_cnt <= '0;
`ifdef MULDIV_DIV_EN
                        r_isdiv <= op[1];
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
`else
                        if (op[1]) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end
`endif
                    end else if (!start) begin
                        if (mthi) r_hi <= wdata;
                        if (mtlo) r_lo <= wdata;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == LAST) r_state <= S_SIGN;
`ifdef MULDIV_DIV_EN
                        if (r_isdiv) begin
                            r_acc <= {w_rem_nx, r_acc[WIDTH-2:0], w_qbit};
                            r_ma  <= {r_ma[WIDTH-2:0], r_ma[WIDTH-1]};
                        end else
`endif
                        begin
                            r_acc <= {w_madd, r_acc[WIDTH-1:1]};
                            r_mb  <= {r_mb[0], r_mb[WIDTH-1:1]};
                        end
                    end
                end
                S_SIGN: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (!flush) begin
                        r_hi   <= w_res_hi;
                        r_lo   <= w_res_lo;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random operations against an arithmetic model.
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          flush;
    logic          mthi;
    logic          mtlo;
    logic [W-1:0]  wdata;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Architectural result of one operation, given HI/LO before it
    function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic [W-1:0] ph, input logic [W-1:0] pl,
                                  output logic [W-1:0] eh, output logic [W-1:0] el);
        longint     p;
        logic [63:0] u;
        eh = ph;
        el = pl;
        case (o)
            2'b00: begin
                p = longint'($signed(x)) * longint'($signed(y));
                {eh, el} = 64'(p);
            end
            2'b01: begin
                u = {32'b0, x} * {32'b0, y};
                {eh, el} = u;
            end
            default: begin
                if (DIV_EN) begin
                    if (y == 0) begin
                        el = '1;
                        eh = x;
                    end else if (o == 2'b10) begin
                        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                            el = 32'h8000_0000;
                            eh = 0;
                        end else begin
                            el = $signed(x) / $signed(y);
                            eh = $signed(x) % $signed(y);
                        end
                    end else begin
                        el = x / y;
                        eh = x % y;
                    end
                end
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] o);
        return (o[1] && !DIV_EN) ? 0 : W + 1;
    endfunction

    // Issue one op; k_done is the edge index (after E0) whose following cycle shows done
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit now, output int k_done, output int nbusy);
        if (!now) @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start  = 1'b0;
        k_done = -1;
        nbusy  = 0;
        for (int k = 0; k < 100; k++) begin
            if (busy) nbusy++;
            if (done) begin
                k_done = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic op_check(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                            input logic [W-1:0] y, input bit now);
        logic [W-1:0] eh;
        logic [W-1:0] el;
        int kd;
        int nb;
        model(o, x, y, hi, lo, eh, el);
        run_op(o, x, y, now, kd, nb);
        chk({tag, "_lat"},  64'(kd), 64'(exp_lat(o)));
        chk({tag, "_busy"}, 64'(nb), 64'(exp_lat(o)));
        chk({tag, "_hi"},   64'(hi), 64'(eh));
        chk({tag, "_lo"},   64'(lo), 64'(el));
    endtask

    initial begin
        int           kd;
        int           nd;
        logic [1:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        flush = 1'b0; mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        #1 reset = 1'b0;
        #1;
        chk("rst_hi",   64'(hi),   64'd0);
        chk("rst_lo",   64'(lo),   64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        op_check("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
        @(negedge clk);
        chk("mult_done_once", 64'(done), 64'd0);
        chk("mult_idle_busy", 64'(busy), 64'd0);

        op_check("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        x = $urandom;
        y = $urandom;
        op_check("b2b", 2'b00, x, y, 1'b1);

        op_check("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        op_check("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        op_check("divu_zero", 2'b11, 32'd100, 32'd0, 1'b0);
        op_check("div_zero",  2'b10, 32'hFFFF_FFF0, 32'd0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            case ($urandom_range(0, 3))
                0:       y = '0;
                1:       y = $urandom_range(1, 9);
                2:       y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            op_check("rnd", o, x, y, 1'b0);
        end

        // MTHI/MTLO
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h33;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        chk("mt_both_hi", 64'(hi), 64'h33);
        chk("mt_both_lo", 64'(lo), 64'h33);
        mthi = 1'b1; wdata = 32'h11;
        @(negedge clk);
        mthi = 1'b0;
        chk("mthi", 64'(hi), 64'h11);
        mtlo = 1'b1; wdata = 32'h22;
        @(negedge clk);
        mtlo = 1'b0;
        chk("mtlo", 64'(lo), 64'h22);

        // Flush mid-RUN
        start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("flush_nodone", 64'(nd), 64'd0);
        chk("flush_hi", 64'(hi), 64'h11);
        chk("flush_lo", 64'(lo), 64'h22);

        // MTLO and START while busy are ignored
        start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        mtlo = 1'b1; wdata = 32'hABCD;
        @(negedge clk);
        mtlo = 1'b0;
        chk("busy_mtlo_lo", 64'(lo), 64'h22);
        start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_busy", 64'(busy), 64'd1);
        kd = -1;
        for (int k = 5; k < 100; k++) begin
            if (done) begin
                kd = k;
                break;
            end
            @(negedge clk);
        end
        chk("busy_start_lat", 64'(kd), 64'(W + 1));
        chk("busy_start_lo",  64'(lo), 64'd25);
        chk("busy_start_hi",  64'(hi), 64'd0);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        mthi = 1'b1; wdata = 32'h77;
        @(negedge clk);
        mthi = 1'b0;
        start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_hi",   64'(hi),   64'd0);
        chk("async_rst_lo",   64'(lo),   64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        x = $urandom;
        y = $urandom;
        op_check("post_rst", 2'b00, x, y, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
